// File: rtl/gumnut_alu_seq.sv
// Gumnut ALU/shifter with valid/ready handshake and architectural carry/zero flags.
// Shifts complete in one cycle (barrel) or one bit per cycle when ITERATIVE != 0.
module gumnut_alu_seq #(
  parameter int DW        = 8,
  parameter int CW        = 3,
  parameter int ITERATIVE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          op_shift,
  input  logic [2:0]    alu_fn,
  input  logic [1:0]    shift_fn,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic [CW-1:0] count,
  input  logic          flags_we,
  output logic          out_valid,
  output logic [DW-1:0] result,
  output logic          res_c,
  output logic          res_z,
  output logic          cc_c,
  output logic          cc_z
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] result_q, result_d;
  logic          res_c_q, res_c_d, res_z_q, res_z_d;
  logic          cc_c_q, cc_c_d, cc_z_q, cc_z_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] sh_q, sh_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [1:0]    fn_q, fn_d;
  logic          fwe_q, fwe_d;

  logic          accept, iter_start, done;
  logic [DW:0]   alu_sum, sw;
  logic [DW-1:0] imm_res, step_sh;
  logic          imm_c, step_c;

  assign in_ready   = (state_q == IDLE) & ~rst;
  assign accept     = in_valid & in_ready;
  assign iter_start = accept & op_shift & (ITERATIVE != 0) & (count != '0);
  assign done       = (state_q == RUN) && (rem_q == CW'(1));

  // Single-cycle result; the extra MSB/LSB of alu_sum and sw carries res_c.
  always_comb begin
    alu_sum = '0;
    sw      = '0;
    imm_res = '0;
    imm_c   = 1'b0;
    if (!op_shift) begin
      unique case (alu_fn)
        3'b000: alu_sum = {1'b0, opa} + {1'b0, opb};
        3'b001: alu_sum = {1'b0, opa} + {1'b0, opb} + {{DW{1'b0}}, cc_c_q};
        3'b010: alu_sum = {1'b0, opa} - {1'b0, opb};
        3'b011: alu_sum = {1'b0, opa} - {1'b0, opb} - {{DW{1'b0}}, cc_c_q};
        3'b100: alu_sum = {1'b0, opa & opb};
        3'b101: alu_sum = {1'b0, opa | opb};
        3'b110: alu_sum = {1'b0, opa ^ opb};
        default: alu_sum = {1'b0, opa & ~opb};
      endcase
      imm_res = alu_sum[DW-1:0];
      imm_c   = alu_sum[DW];
    end else begin
      unique case (shift_fn)
        2'b00: begin
          sw      = {1'b0, opa} << count;
          imm_res = sw[DW-1:0];
          imm_c   = sw[DW];
        end
        2'b01: begin
          sw      = {opa, 1'b0} >> count;
          imm_res = sw[DW:1];
          imm_c   = sw[0];
        end
        2'b10: begin
          imm_res = (opa << count) | (opa >> (DW - int'(count)));
          imm_c   = imm_res[0];
        end
        default: begin
          imm_res = (opa >> count) | (opa << (DW - int'(count)));
          imm_c   = imm_res[DW-1];
        end
      endcase
    end
  end

  // One iterative step; the bit leaving the word is the carry for every shift kind.
  always_comb begin
    step_sh = sh_q;
    step_c  = 1'b0;
    unique case (fn_q)
      2'b00:   begin step_sh = sh_q << 1;                   step_c = sh_q[DW-1]; end
      2'b01:   begin step_sh = sh_q >> 1;                   step_c = sh_q[0];    end
      2'b10:   begin step_sh = {sh_q[DW-2:0], sh_q[DW-1]}; step_c = sh_q[DW-1]; end
      default: begin step_sh = {sh_q[0], sh_q[DW-1:1]};    step_c = sh_q[0];    end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      result_q    <= '0;
      res_c_q     <= 1'b0;
      res_z_q     <= 1'b0;
      cc_c_q      <= 1'b0;
      cc_z_q      <= 1'b0;
      out_valid_q <= 1'b0;
      sh_q        <= '0;
      rem_q       <= '0;
      fn_q        <= '0;
      fwe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      res_c_q     <= res_c_d;
      res_z_q     <= res_z_d;
      cc_c_q      <= cc_c_d;
      cc_z_q      <= cc_z_d;
      out_valid_q <= out_valid_d;
      sh_q        <= sh_d;
      rem_q       <= rem_d;
      fn_q        <= fn_d;
      fwe_q       <= fwe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (iter_start) state_d = RUN;
      RUN:     if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = 1'b0;
    result_d    = result_q;
    res_c_d     = res_c_q;
    res_z_d     = res_z_q;
    cc_c_d      = cc_c_q;
    cc_z_d      = cc_z_q;
    sh_d        = sh_q;
    rem_d       = rem_q;
    fn_d        = fn_q;
    fwe_d       = fwe_q;
    if (accept && !iter_start) begin
      out_valid_d = 1'b1;
      result_d    = imm_res;
      res_c_d     = imm_c;
      res_z_d     = (imm_res == '0);
      if (flags_we) begin
        cc_c_d = imm_c;
        cc_z_d = (imm_res == '0);
      end
    end
    if (iter_start) begin
      sh_d  = opa;
      rem_d = count;
      fn_d  = shift_fn;
      fwe_d = flags_we;
    end
    if (state_q == RUN) begin
      sh_d  = step_sh;
      rem_d = rem_q - CW'(1);
      if (done) begin
        out_valid_d = 1'b1;
        result_d    = step_sh;
        res_c_d     = step_c;
        res_z_d     = (step_sh == '0);
        if (fwe_q) begin
          cc_c_d = step_c;
          cc_z_d = (step_sh == '0);
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign res_c     = res_c_q;
  assign res_z     = res_z_q;
  assign cc_c      = cc_c_q;
  assign cc_z      = cc_z_q;

endmodule
